demux14: RTL

Clocked 1:4 demultiplexer that distributes one 4-bit valid-qualified stream round-robin across four lanes, each carrying 4 bits of data and a valid. It is the receive-side counterpart of the 4:1 mux tree. That tree merges four lanes into one stream. This block splits the stream back into four lanes in the same lane order, 0, 1, 2, 3, and then 0 again.

---
 rtl/demux14_if.sv | 35 +++
 rtl/demux14.sv | 55 +++++
 2 files changed

// File: rtl/demux14_if.sv
// Stream/lane bundle for demux14: one 4-bit valid-qualified input stream, four output lanes.
// word_count exists only when DEMUX14_WORDCOUNT_EN is defined.
interface demux14_if;
    logic [3:0] data_in;
    logic       valid_in;
    logic [3:0] data_out_0;
    logic [3:0] data_out_1;
    logic [3:0] data_out_2;
    logic [3:0] data_out_3;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       valid_out_2;
    logic       valid_out_3;
`ifdef DEMUX14_WORDCOUNT_EN
    logic [7:0] word_count;
`endif

    modport master (
        output data_in, output valid_in,
        input  data_out_0, input data_out_1, input data_out_2, input data_out_3,
        input  valid_out_0, input valid_out_1, input valid_out_2, input valid_out_3
`ifdef DEMUX14_WORDCOUNT_EN
        , input word_count
`endif
    );

    modport slave (
        input  data_in, input valid_in,
        output data_out_0, output data_out_1, output data_out_2, output data_out_3,
        output valid_out_0, output valid_out_1, output valid_out_2, output valid_out_3
`ifdef DEMUX14_WORDCOUNT_EN
        , output word_count
`endif
    );
endinterface

// File: rtl/demux14.sv
// Clocked 1:4 round-robin demultiplexer; idle cycles do not advance the lane pointer.
// Optional DEMUX14_WORDCOUNT_EN adds an 8-bit wrapping delivered-word counter.
module demux14 (
    input  logic      clk,
    input  logic      reset_L,
    demux14_if.slave  bus
);
    typedef enum logic [1:0] {LANE0 = 2'd0, LANE1 = 2'd1, LANE2 = 2'd2, LANE3 = 2'd3} lane_t;

    lane_t      lane;
    logic [3:0] data_q [4];
    logic [3:0] valid_q;
`ifdef DEMUX14_WORDCOUNT_EN
    logic [7:0] word_count_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            lane    <= LANE0;
            valid_q <= '0;
            for (int unsigned i = 0; i < 4; i++) data_q[i] <= '0;
`ifdef DEMUX14_WORDCOUNT_EN
            word_count_q <= '0;
`endif
        end else begin
            valid_q <= '0;
            if (bus.valid_in) begin
                // data registers are written only on valid words, so idle data never reaches them
                data_q[lane]  <= bus.data_in;
                valid_q[lane] <= 1'b1;
                case (lane)
                    LANE0:   lane <= LANE1;
                    LANE1:   lane <= LANE2;
                    LANE2:   lane <= LANE3;
                    default: lane <= LANE0;
                endcase
`ifdef DEMUX14_WORDCOUNT_EN
                word_count_q <= word_count_q + 8'd1;
`endif
            end
        end
    end

    assign bus.data_out_0  = data_q[0];
    assign bus.data_out_1  = data_q[1];
    assign bus.data_out_2  = data_q[2];
    assign bus.data_out_3  = data_q[3];
    assign bus.valid_out_0 = valid_q[0];
    assign bus.valid_out_1 = valid_q[1];
    assign bus.valid_out_2 = valid_q[2];
    assign bus.valid_out_3 = valid_q[3];
`ifdef DEMUX14_WORDCOUNT_EN
    assign bus.word_count  = word_count_q;
`endif
endmodule
